// File: rtl/wb_trace_serializer_if.sv
// Bundle carrying both writeback channels into the serializer and the single
// in-order commit stream plus status back out.
interface wb_trace_serializer_if #(
  parameter int unsigned DEPTH = 8
);
  logic                     in0_en;
  logic [4:0]               in0_rd;
  logic [31:0]              in0_wdata;
  logic [31:0]              in0_pc;
  logic                     in1_en;
  logic [4:0]               in1_rd;
  logic [31:0]              in1_wdata;
  logic [31:0]              in1_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [4:0]               out_rd;
  logic [31:0]              out_wdata;
  logic [3:0]               out_wen;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic [31:0]              commit_cnt;

  modport slave (
    input  in0_en, in0_rd, in0_wdata, in0_pc,
    input  in1_en, in1_rd, in1_wdata, in1_pc,
    input  out_ready,
    output out_valid, out_pc, out_rd, out_wdata, out_wen,
    output level, overflow, commit_cnt
  );

  modport master (
    output in0_en, in0_rd, in0_wdata, in0_pc,
    output in1_en, in1_rd, in1_wdata, in1_pc,
    output out_ready,
    input  out_valid, out_pc, out_rd, out_wdata, out_wen,
    input  level, overflow, commit_cnt
  );
endinterface

// File: rtl/wb_trace_serializer.sv
// Merges the two per-cycle writeback channels into one ordered commit stream
// through a small FIFO; both channels of a cycle are admitted or dropped together.
module wb_trace_serializer #(
  parameter int unsigned DEPTH   = 8,
  parameter bit          DROP_R0 = 1'b1
) (
  input logic               sys_clk,
  input logic               resetn,
  wb_trace_serializer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   commits;

  logic          elig0;
  logic          elig1;
  logic [1:0]    n_push;
  logic [CW:0]   need;
  logic          admit;
  logic          push_ok;
  logic          pop;
  logic [CW-1:0] n_acc;
  logic [CW-1:0] count_nxt;
  entry_t        ent0;
  entry_t        ent1;
  entry_t        first;

  always_comb begin
    elig0   = bus.in0_en && !(DROP_R0 && (bus.in0_rd == 5'd0));
    elig1   = bus.in1_en && !(DROP_R0 && (bus.in1_rd == 5'd0));
    n_push  = {1'b0, elig0} + {1'b0, elig1};
    ent0    = '{pc: bus.in0_pc, rd: bus.in0_rd, wdata: bus.in0_wdata};
    ent1    = '{pc: bus.in1_pc, rd: bus.in1_rd, wdata: bus.in1_wdata};
    // A lone channel-1 write takes the first free slot, so nothing is skipped.
    first   = elig0 ? ent0 : ent1;
    // Admission looks only at the registered count; a concurrent pop frees nothing.
    need    = {1'b0, count} + (CW+1)'(n_push);
    admit   = (need <= (CW+1)'(DEPTH));
    push_ok = admit && (n_push != 2'd0);
    pop     = (count != '0) && bus.out_ready;
    n_acc   = push_ok ? CW'(n_push) : '0;
    count_nxt = count + n_acc - CW'(pop);
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      commits <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(n_push);
      if (pop) begin
        head    <= head + PW'(1);
        commits <= commits + 32'd1;
      end
      count <= count_nxt;
      if (!admit) ovf <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (resetn && push_ok) begin
      mem[tail] <= first;
      if (n_push == 2'd2) mem[tail + PW'(1)] <= ent1;
    end
  end

  assign bus.out_valid  = (count != '0);
  assign bus.out_pc     = mem[head].pc;
  assign bus.out_rd     = mem[head].rd;
  assign bus.out_wdata  = mem[head].wdata;
  assign bus.out_wen    = {4{bus.out_valid}};
  assign bus.level      = count;
  assign bus.overflow   = ovf;
  assign bus.commit_cnt = commits;
endmodule

// File: tb/tb_wb_trace_serializer.sv
// Randomized and directed check of wb_trace_serializer against a queue-based
// reference model of the commit stream.
module tb_wb_trace_serializer;
  localparam int unsigned DEPTH   = 8;
  localparam bit          DROP_R0 = 1'b1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  logic sys_clk = 1'b0;
  logic resetn  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  ent_t        q[$];
  bit          m_ovf    = 1'b0;
  logic [31:0] m_commit = '0;

  wb_trace_serializer_if #(.DEPTH(DEPTH)) bus ();

  wb_trace_serializer #(.DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the inputs presented to it.
  task automatic model_edge();
    ent_t nw[$];
    int   pre;
    if (!resetn) begin
      q.delete();
      m_ovf    = 1'b0;
      m_commit = '0;
      return;
    end
    if (bus.in0_en && !(DROP_R0 && bus.in0_rd == 0))
      nw.push_back('{pc: bus.in0_pc, rd: bus.in0_rd, wdata: bus.in0_wdata});
    if (bus.in1_en && !(DROP_R0 && bus.in1_rd == 0))
      nw.push_back('{pc: bus.in1_pc, rd: bus.in1_rd, wdata: bus.in1_wdata});
    pre = q.size();
    if (pre + nw.size() <= DEPTH) begin
      foreach (nw[i]) q.push_back(nw[i]);
    end else begin
      m_ovf = 1'b1;
    end
    if (pre > 0 && bus.out_ready) begin
      void'(q.pop_front());
      m_commit = m_commit + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("wen", 64'(bus.out_wen), (q.size() != 0) ? 64'hf : 64'h0);
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("commit_cnt", 64'(bus.commit_cnt), 64'(m_commit));
    if (q.size() != 0) begin
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_wdata", 64'(bus.out_wdata), 64'(q[0].wdata));
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit e0, input logic [4:0] r0, input logic [31:0] p0,
                        input logic [31:0] d0, input bit e1, input logic [4:0] r1,
                        input logic [31:0] p1, input logic [31:0] d1, input bit rdy);
    bus.in0_en = e0; bus.in0_rd = r0; bus.in0_pc = p0; bus.in0_wdata = d0;
    bus.in1_en = e1; bus.in1_rd = r1; bus.in1_pc = p1; bus.in1_wdata = d1;
    bus.out_ready = rdy;
  endtask

  task automatic idle(input bit rdy);
    set_in(1'b0, 5'd0, '0, '0, 1'b0, 5'd0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic dual(input logic [31:0] pc, input bit rdy);
    set_in(1'b1, 5'd1, pc, pc ^ 32'h5a5a, 1'b1, 5'd2, pc + 32'd4, pc ^ 32'ha5a5, rdy);
    step();
  endtask

  initial begin
    idle(1'b0);
    step();
    do_reset();
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);

    // Dual push into empty FIFO, then drain.
    set_in(1'b1, 5'd2, 32'hbfc00000, 32'd1, 1'b1, 5'd3, 32'hbfc00004, 32'd2, 1'b1);
    step();
    chk("dual_pc0", 64'(bus.out_pc), 64'hbfc00000);
    idle(1'b1);
    step();
    chk("dual_pc1", 64'(bus.out_pc), 64'hbfc00004);
    step();
    chk("dual_commit", 64'(bus.commit_cnt), 64'd2);

    // rd==0 on channel 0 is discarded; channel 1 lands in the first slot.
    do_reset();
    set_in(1'b1, 5'd0, 32'hbfc0000c, 32'd7, 1'b1, 5'd5, 32'hbfc00010, 32'd9, 1'b0);
    step();
    chk("r0_level", 64'(bus.level), 64'd1);
    chk("r0_pc", 64'(bus.out_pc), 64'hbfc00010);

    // Fill to DEPTH, then an overflowing dual push.
    do_reset();
    for (int i = 0; i < 4; i++) dual(32'h1000 + 32'(i) * 8, 1'b0);
    chk("full_level", 64'(bus.level), 64'd8);
    chk("full_ovf", 64'(bus.overflow), 64'd0);
    dual(32'h2000, 1'b0);
    chk("ovf_level", 64'(bus.level), 64'd8);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);

    // level=7: a same-cycle pop does not make room for a dual push.
    do_reset();
    for (int i = 0; i < 3; i++) dual(32'h3000 + 32'(i) * 8, 1'b0);
    set_in(1'b1, 5'd4, 32'h3100, 32'd4, 1'b0, 5'd0, '0, '0, 1'b0);
    step();
    chk("l7_level", 64'(bus.level), 64'd7);
    dual(32'h3200, 1'b1);
    chk("l7_after", 64'(bus.level), 64'd6);
    chk("l7_ovf", 64'(bus.overflow), 64'd1);

    // Streaming one in / one out across pointer wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 5'(i % 31 + 1), 32'h4000 + 32'(i) * 4, 32'(i), 1'b0, 5'd0, '0, '0, 1'b1);
      step();
    end
    chk("stream_level", 64'(bus.level), 64'd1);
    chk("stream_commit", 64'(bus.commit_cnt), 64'd19);

    // Reset with level=5 and overflow set; pushes during reset are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) dual(32'h5000 + 32'(i) * 8, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_level", 64'(bus.level), 64'd5);
    chk("pre_rst_ovf", 64'(bus.overflow), 64'd1);
    set_in(1'b1, 5'd6, 32'h6000, 32'd6, 1'b1, 5'd7, 32'h6004, 32'd7, 1'b1);
    do_reset();
    chk("post_rst_level", 64'(bus.level), 64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_ovf", 64'(bus.overflow), 64'd0);
    chk("post_rst_commit", 64'(bus.commit_cnt), 64'd0);
    // First edge after release accepts the held dual push.
    step();
    chk("first_push_level", 64'(bus.level), 64'd2);

    // Random traffic with varying back-pressure and occasional reset.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        set_in(1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom(), $urandom(),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom(), $urandom(),
               1'($urandom_range(0, 3) < ph + 1));
        resetn = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
